// File: rtl/mem_ctrl_pkg.sv
// Shared types and defaults for the data-memory controller and its write buffer.
package mem_ctrl_pkg;

  localparam int DEFAULT_WB_DEPTH = 2;
  localparam int DEFAULT_TIMEOUT  = 255;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WR_BUS  = 2'd1,
    RD_BUS  = 2'd2,
    RD_DONE = 2'd3
  } state_e;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wb_entry_t;

endpackage

// File: rtl/write_buffer.sv
// Circular store buffer: FIFO drain from the head, plus a lookup that
// returns the data of the youngest entry whose address matches.
module write_buffer
  import mem_ctrl_pkg::*;
#(
  parameter int DEPTH = DEFAULT_WB_DEPTH
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  wb_entry_t                    push_entry,
  input  logic                         pop,
  output wb_entry_t                    head,
  input  logic [31:0]                  lookup_addr,
  output logic                         hit,
  output logic [31:0]                  hit_data,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  wb_entry_t          mem_q [DEPTH];
  wb_entry_t          mem_d [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [PTR_W-1:0]   scan_idx;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) return '0;
    return p + PTR_W'(1);
  endfunction

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_entry;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);
  end

  // Walk oldest to youngest so the last match seen is the youngest one.
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    scan_idx = rd_ptr_q;
    for (int i = 0; i < DEPTH; i++) begin
      if ((CNT_W'(i) < count_q) && (mem_q[scan_idx].addr == lookup_addr)) begin
        hit      = 1'b1;
        hit_data = mem_q[scan_idx].data;
      end
      scan_idx = ptr_inc(scan_idx);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign head  = mem_q[rd_ptr_q];
  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;

endmodule

// File: rtl/data_mem_ctrl.sv
// Data-memory controller: buffers stores, forwards loads from the buffer,
// and serialises write drains and load misses onto a req/ack memory bus.
module data_mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int WB_DEPTH = DEFAULT_WB_DEPTH,
  parameter int TIMEOUT  = DEFAULT_TIMEOUT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        misalign,
  output logic        bus_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack
);

  localparam int CNT_W = $clog2(WB_DEPTH + 1);
  localparam int TO_W  = $clog2(TIMEOUT + 1);

  state_e           state_q, state_d;
  logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
  logic [31:0]      bus_addr_q, bus_addr_d;
  logic [31:0]      bus_wdata_q, bus_wdata_d;
  logic [31:0]      rd_buf_q, rd_buf_d;
  logic             bus_err_q, bus_err_d;

  logic             aligned, wr_req, rd_req, rd_miss, timed_out;
  logic             wb_push, wb_pop, wb_hit, wb_full, wb_empty;
  logic [31:0]      wb_hit_data;
  logic [CNT_W-1:0] wb_count;
  wb_entry_t        wb_in, wb_head;

  assign aligned   = (addr[1:0] == 2'b00);
  assign wr_req    = mem_write & aligned;
  assign rd_req    = mem_read & ~mem_write & aligned;
  assign rd_miss   = rd_req & ~wb_hit;
  assign wb_push   = wr_req & (wb_count < CNT_W'(WB_DEPTH));
  assign timed_out = (to_cnt_q == TO_W'(TIMEOUT - 1));
  assign wb_in.addr = addr;
  assign wb_in.data = wdata;

  write_buffer #(.DEPTH(WB_DEPTH)) u_write_buffer (
    .clk         (clk),
    .reset       (reset),
    .push        (wb_push),
    .push_entry  (wb_in),
    .pop         (wb_pop),
    .head        (wb_head),
    .lookup_addr (addr),
    .hit         (wb_hit),
    .hit_data    (wb_hit_data),
    .full        (wb_full),
    .empty       (wb_empty),
    .count       (wb_count)
  );

  // Buffered writes always drain before a read miss may use the bus.
  always_comb begin
    state_d     = state_q;
    to_cnt_d    = to_cnt_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    rd_buf_d    = rd_buf_q;
    bus_err_d   = bus_err_q;
    wb_pop      = 1'b0;
    case (state_q)
      IDLE: begin
        to_cnt_d = '0;
        if (!wb_empty) begin
          state_d     = WR_BUS;
          bus_addr_d  = wb_head.addr;
          bus_wdata_d = wb_head.data;
        end else if (rd_miss) begin
          state_d    = RD_BUS;
          bus_addr_d = addr;
        end
      end
      WR_BUS: begin
        if (bus_ack || timed_out) begin
          wb_pop    = 1'b1;
          to_cnt_d  = '0;
          state_d   = IDLE;
          bus_err_d = bus_err_q | ~bus_ack;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end
      RD_BUS: begin
        if (bus_ack || timed_out) begin
          rd_buf_d  = bus_ack ? bus_rdata : 32'h0;
          to_cnt_d  = '0;
          state_d   = RD_DONE;
          bus_err_d = bus_err_q | ~bus_ack;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end
      RD_DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      to_cnt_q    <= '0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      rd_buf_q    <= '0;
      bus_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      to_cnt_q    <= to_cnt_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      rd_buf_q    <= rd_buf_d;
      bus_err_q   <= bus_err_d;
    end
  end

  // A read miss is released only in RD_DONE, the one cycle holding the bus result.
  always_comb begin
    stall    = 1'b0;
    misalign = 1'b0;
    rdata    = '0;
    if (!reset) begin
      misalign = (mem_read | mem_write) & ~aligned;
      if (wr_req) begin
        stall = wb_full;
      end else if (rd_req) begin
        if (wb_hit) begin
          rdata = wb_hit_data;
        end else if (state_q == RD_DONE) begin
          rdata = rd_buf_q;
        end else begin
          stall = 1'b1;
        end
      end
    end
  end

  assign bus_req   = ~reset & ((state_q == WR_BUS) | (state_q == RD_BUS));
  assign bus_we    = ~reset & (state_q == WR_BUS);
  assign bus_addr  = bus_addr_q;
  assign bus_wdata = bus_wdata_q;
  assign bus_err   = bus_err_q;

endmodule
